// File: rtl/qspi_fetch_cache.sv
`timescale 1ns/1ps
// qspi_fetch_cache: direct-mapped, read-only, one-word-per-line cache that
// sits between the CPU fetch bus and the QSPI flash reader (rom_qspi).
// A hit answers one cycle after the request is sampled. A miss issues a single
// 32-bit read to the flash reader and answers the cycle after its ready pulse.
// Optional next-word prefetch after a miss: define QSPI_FETCH_PREFETCH_EN.
//
// state  | meaning
// IDLE   | waiting for cpu_req; captures the address
// LOOKUP | tag compare; a hit answers from here, a miss starts a flash read
// FILL   | flash read of the demand word in flight
// RESP   | cpu_rdy cycle of a miss (data latched in the fl_rdy cycle)
// PREF   | flash read of the following word in flight (prefetch builds only)

module qspi_fetch_cache #(
   parameter int AW    = 24,
   parameter int LINES = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_rdy,
   input  logic          inv,
   output logic [AW-1:0] fl_addr,
   output logic [1:0]    fl_bsz,
   output logic          fl_trigger,
   input  logic [31:0]   fl_rdata,
   input  logic          fl_rdy
);

   localparam int IW = $clog2(LINES);
   localparam int TW = AW - IW - 2;

`ifdef QSPI_FETCH_PREFETCH_EN
   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP, PREF} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP} state_t;
`endif

   state_t            state;
   logic [AW-3:0]     wa_q;        // captured word address (byte address A >> 2)
   logic [LINES-1:0]  valid_q;
   logic              inv_pend;    // an invalidate landed while the read was in flight
   logic [31:0]       data_q [LINES];
   logic [TW-1:0]     tag_q  [LINES];

   logic [IW-1:0]     idx;
   logic [TW-1:0]     tag;
   logic              hit;
   logic              fill_we;

   // byte offset within the word is irrelevant to a word cache
   wire unused_byte_offset = &{1'b0, cpu_addr[1:0]};

   assign fl_bsz  = 2'b00;
   assign idx     = wa_q[IW-1:0];
   assign tag     = wa_q[AW-3:IW];
   assign hit     = valid_q[idx] && (tag_q[idx] == tag);
`ifdef QSPI_FETCH_PREFETCH_EN
   assign fill_we = ((state == FILL) || (state == PREF)) && fl_rdy;
`else
   assign fill_we = (state == FILL) && fl_rdy;
`endif

`ifdef QSPI_FETCH_PREFETCH_EN
   // following word; the word address wraps, which is A+4 mod 2^AW
   logic [AW-3:0] wa_nxt;
   logic [IW-1:0] nidx;
   logic [TW-1:0] ntag;
   logic          nhit;
   assign wa_nxt = wa_q + 1'b1;
   assign nidx   = wa_nxt[IW-1:0];
   assign ntag   = wa_nxt[AW-3:IW];
   assign nhit   = valid_q[nidx] && (tag_q[nidx] == ntag);
`endif

   // data and tag arrays: written on every completed flash read, never reset
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[idx] <= fl_rdata;
         tag_q[idx]  <= tag;
      end
   end

   // control FSM with registered CPU and flash-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wa_q       <= '0;
         valid_q    <= '0;
         inv_pend   <= 1'b0;
         cpu_rdy    <= 1'b0;
         cpu_rdata  <= 32'h0;
         fl_trigger <= 1'b0;
         fl_addr    <= '0;
      end else begin
         cpu_rdy <= 1'b0;
         if (inv)
            valid_q <= '0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  wa_q  <= cpu_addr[AW-1:2];
                  state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  cpu_rdy   <= 1'b1;
                  cpu_rdata <= data_q[idx];
                  state     <= IDLE;
               end else begin
                  fl_addr    <= {wa_q, 2'b00};
                  fl_trigger <= 1'b1;
                  inv_pend   <= 1'b0;
                  state      <= FILL;
               end
            end
            FILL: begin
               if (inv)
                  inv_pend <= 1'b1;
               if (fl_rdy) begin
                  fl_trigger <= 1'b0;
                  if (!(inv || inv_pend))
                     valid_q[idx] <= 1'b1;
                  cpu_rdy   <= 1'b1;
                  cpu_rdata <= fl_rdata;
                  state     <= RESP;
               end
            end
            RESP: begin
`ifdef QSPI_FETCH_PREFETCH_EN
               if (!nhit) begin
                  wa_q       <= wa_nxt;
                  fl_addr    <= {wa_nxt, 2'b00};
                  fl_trigger <= 1'b1;
                  inv_pend   <= 1'b0;
                  state      <= PREF;
               end else begin
                  state <= IDLE;
               end
`else
               state <= IDLE;
`endif
            end
`ifdef QSPI_FETCH_PREFETCH_EN
            PREF: begin
               // a waiting cpu_req is picked up in IDLE once this fill lands
               if (inv)
                  inv_pend <= 1'b1;
               if (fl_rdy) begin
                  fl_trigger <= 1'b0;
                  if (!(inv || inv_pend))
                     valid_q[idx] <= 1'b1;
                  state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_fetch_cache.sv
`timescale 1ns/1ps
// Directed bench for qspi_fetch_cache with a behavioural flash reader that
// answers each trigger after a programmable number of cycles.

module tb_qspi_fetch_cache;

   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_rdata;
   logic          cpu_rdy;
   logic          inv;
   logic [AW-1:0] fl_addr;
   logic [1:0]    fl_bsz;
   logic          fl_trigger;
   logic [31:0]   fl_rdata;
   logic          fl_rdy;

   int errors = 0;
   int checks = 0;
   int nreads = 0;
   int lat_cfg = 5;
   int resp_cnt = 0;
   logic [AW-1:0] last_addr = '0;

   // results of the most recent do_read
   logic [31:0]   r_data;
   int            r_lat;
   int            r_nrd;
   logic          r_after_fl;
   logic          r_trig;
   logic [AW-1:0] r_addr;

   qspi_fetch_cache #(.AW(AW), .LINES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_rdata  (cpu_rdata),
      .cpu_rdy    (cpu_rdy),
      .inv        (inv),
      .fl_addr    (fl_addr),
      .fl_bsz     (fl_bsz),
      .fl_trigger (fl_trigger),
      .fl_rdata   (fl_rdata),
      .fl_rdy     (fl_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] flash_word(input logic [AW-1:0] a);
      case (a)
         24'h000000: flash_word = 32'hDEADBEEF;
         24'h000040: flash_word = 32'h11111111;
         24'h000008: flash_word = 32'hCAFEF00D;
         default:    flash_word = {8'h5A, a};
      endcase
   endfunction

   // flash reader model: acts just after each rising edge
   initial begin
      fl_rdy   = 1'b0;
      fl_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (fl_rdy) begin
            fl_rdy = 1'b0;
         end else if (rst) begin
            resp_cnt = 0;
         end else if (fl_trigger) begin
            if (resp_cnt >= lat_cfg) begin
               fl_rdy    = 1'b1;
               fl_rdata  = flash_word(fl_addr);
               last_addr = fl_addr;
               nreads++;
               resp_cnt  = 0;
            end else begin
               resp_cnt++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   // wait until no flash read (demand or prefetch) is outstanding
   task automatic idle_wait();
      int g;
      g = 0;
      repeat (2) @(negedge clk);
      while (fl_trigger && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (fl_trigger)
         check("idle_timeout", {31'b0, fl_trigger}, 32'h0);
   endtask

   // one CPU read; inv_at = negedge index to pulse inv (0 = with the request, -1 = none)
   task automatic do_read(input logic [AW-1:0] a, input int inv_at);
      int   n0;
      logic prev_fl;
      idle_wait();
      n0 = nreads;
      prev_fl = 1'b0;
      r_lat = 0;
      r_trig = 1'b0;
      r_addr = '0;
      cpu_addr = a;
      cpu_req = 1'b1;
      inv = (inv_at == 0);
      while (r_lat < 200) begin
         @(negedge clk);
         r_lat++;
         inv = (inv_at == r_lat);
         if (r_lat == 3) begin
            r_trig = fl_trigger;
            r_addr = fl_addr;
         end
         if (cpu_rdy) break;
         prev_fl = fl_rdy;
      end
      cpu_req = 1'b0;
      inv = 1'b0;
      if (!cpu_rdy)
         check("rd_timeout", {31'b0, cpu_rdy}, 32'h1);
      r_data = cpu_rdata;
      r_nrd = nreads - n0;
      r_after_fl = prev_fl;
   endtask

   // read and check data, number of flash reads and latency
   task automatic rd_check(input string name, input logic [AW-1:0] a, input int inv_at,
                           input logic [31:0] exp_data, input int exp_nrd);
      do_read(a, inv_at);
      check({name, "_data"}, r_data, exp_data);
      check({name, "_nreads"}, r_nrd, exp_nrd);
      if (exp_nrd == 0)
         check({name, "_hitlat"}, r_lat, 32'd2);
      else
         check({name, "_after_flrdy"}, {31'b0, r_after_fl}, 32'h1);
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      cpu_req = 1'b0;
      cpu_addr = '0;
      inv = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cpu_rdy", {31'b0, cpu_rdy}, 32'h0);
      check("rst_cpu_rdata", cpu_rdata, 32'h0);
      check("rst_fl_trigger", {31'b0, fl_trigger}, 32'h0);
      check("rst_fl_addr", fl_addr, 32'h0);
      check("fl_bsz", {30'b0, fl_bsz}, 32'h0);

      // cold miss, byte offset ignored
      rd_check("cold", 24'h000003, -1, 32'hDEADBEEF, 1);
      check("cold_trig_held", {31'b0, r_trig}, 32'h1);
      check("cold_fl_addr", r_addr, 32'h000000);
      check("cold_last_addr", last_addr, 32'h000000);
      check("cold_trig_after", {31'b0, fl_trigger}, 32'h0);

      // hit, and cpu_rdy is a single-cycle pulse with rdata held afterwards
      rd_check("hit", 24'h000000, -1, 32'hDEADBEEF, 0);
      @(negedge clk);
      check("hit_rdy_pulse", {31'b0, cpu_rdy}, 32'h0);
      check("hit_rdata_hold", cpu_rdata, 32'hDEADBEEF);
      rd_check("hit_off2", 24'h000002, -1, 32'hDEADBEEF, 0);

      // conflicting tags on line 0 evict each other
      rd_check("conf_a", 24'h000040, -1, 32'h11111111, 1);
      rd_check("conf_b", 24'h000000, -1, 32'hDEADBEEF, 1);
      check("conf_b_addr", last_addr, 32'h000000);
      rd_check("conf_a2", 24'h000040, -1, 32'h11111111, 1);

      // invalidate during FILL: data returned, line left invalid
      rd_check("inv_fill", 24'h000008, 3, 32'hCAFEF00D, 1);
      rd_check("inv_refetch", 24'h000008, -1, 32'hCAFEF00D, 1);
      rd_check("inv_refill_hit", 24'h000008, -1, 32'hCAFEF00D, 0);

      // invalidate together with a request in IDLE: that request misses
      rd_check("inv_req", 24'h000008, 0, 32'hCAFEF00D, 1);

      // reset during FILL
      rd_check("pre_rst_miss", 24'h000000, -1, 32'hDEADBEEF, 1);
      rd_check("pre_rst_hit", 24'h000000, -1, 32'hDEADBEEF, 0);
      idle_wait();
      lat_cfg = 50;
      cpu_addr = 24'h000020;
      cpu_req = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_mid_trig_before", {31'b0, fl_trigger}, 32'h1);
      rst = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      check("rst_mid_trig", {31'b0, fl_trigger}, 32'h0);
      check("rst_mid_rdy", {31'b0, cpu_rdy}, 32'h0);
      rst = 1'b0;
      lat_cfg = 5;
      rd_check("post_rst", 24'h000000, -1, 32'hDEADBEEF, 1);

`ifdef QSPI_FETCH_PREFETCH_EN
      n0 = nreads;
      rd_check("pf_miss", 24'h000010, -1, 32'h5A000010, 1);
      idle_wait();
      check("pf_addr", last_addr, 32'h000014);
      check("pf_nreads", nreads - n0, 32'd2);
      rd_check("pf_hit", 24'h000014, -1, 32'h5A000014, 0);
      @(negedge clk);
      inv = 1'b1;
      @(negedge clk);
      inv = 1'b0;
      rd_check("pf_wrap_miss", 24'hFFFFFC, -1, 32'h5AFFFFFC, 1);
      idle_wait();
      check("pf_wrap_addr", last_addr, 32'h000000);
      rd_check("pf_wrap_hit", 24'h000000, -1, 32'hDEADBEEF, 0);
`else
      n0 = nreads;
      rd_check("nopf_miss", 24'h000010, -1, 32'h5A000010, 1);
      idle_wait();
      check("nopf_idle", nreads - n0, 32'd1);
      rd_check("nopf_next", 24'h000014, -1, 32'h5A000014, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/qspi_fetch_cache.md
Name: qspi_fetch_cache

Overview:
- Small direct-mapped, read-only word cache between the CPU instruction/ROM bus and the QSPI flash ROM reader (rom_qspi).
- On a hit it answers in one cycle. On a miss it issues a single 32-bit word read to the flash reader, holds the request until that reader signals ready, then fills the line and answers the CPU.
- It hides the flash reader's long latency (hundreds of cycles) for loops and repeated fetches.

Parameters:
- AW, 24, byte address width, matching the flash reader's address width.
- LINES, 16, number of one-word lines; power of 2, ≥2. IW = log2(LINES).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  read request level; held until cpu_rdy
- cpu_addr  in  AW  byte address; bits [1:0] ignored
- cpu_rdata  out  32  read data; valid only while cpu_rdy=1
- cpu_rdy  out  1  one-cycle completion pulse
- inv  in  1  one-cycle pulse: invalidate all lines
- fl_addr  out  AW  word-aligned address to flash reader (baddr)
- fl_bsz  out  2  transfer size to flash reader; constant 2'b00 (32-bit word)
- fl_trigger  out  1  read request to flash reader (trigger_rd); level, held until fl_rdy
- fl_rdata  in  32  flash read data (bdo)
- fl_rdy  in  1  flash read complete (brdy)

Behaviour:
- Reset values: cpu_rdy=0, cpu_rdata=0, fl_trigger=0, fl_addr=0, all valid bits=0, state=IDLE. Data and tag arrays are not reset.
- Address split (from the captured address A):
  - idx = A[IW+1:2]
  - tag = A[AW-1:IW+2]
  - fl_addr = {A[AW-1:2], 2'b00}
- State machine:
  - IDLE: if cpu_req=1, capture cpu_addr into A and go to LOOKUP. Any cpu_req=1 seen in IDLE is a new request.
  - LOOKUP, hit (valid[idx] and tag match): cpu_rdy=1 and cpu_rdata=data[idx] for exactly this cycle, then go to IDLE. Hit latency is one cycle after the request is sampled.
  - LOOKUP, miss: register fl_addr, set fl_trigger=1, go to FILL.
  - FILL: fl_trigger and fl_addr stay stable until fl_rdy=1. In the fl_rdy cycle:
    - write data[idx]=fl_rdata and tag[idx]=tag;
    - set valid[idx]=1 unless an invalidate applies (see inv rules);
    - latch fl_rdata for the response;
    - go to RESP.
    - fl_trigger=0 from the next cycle.
  - RESP: cpu_rdy=1 and cpu_rdata=latched fill data, then go to IDLE. Miss latency is fl_rdy cycle + 1.
- Requester rule: cpu_req must be low or carry a new address by the edge that ends the cpu_rdy cycle.
- Outside cpu_rdy cycles, cpu_rdata holds its last value.
- cpu_req/cpu_addr changes during LOOKUP/FILL/RESP are ignored; A is already captured.
- inv rules:
  - inv clears all valid bits at the next edge, in any state.
  - inv during FILL, or coinciding with the fl_rdy cycle: the in-flight line is not marked valid. The data is still returned to the CPU.
  - inv in IDLE coinciding with cpu_req: the clear happens first, so that request misses.
- Reset mid-operation (any state): next cycle state=IDLE, fl_trigger=0, cpu_rdy=0, valids cleared. The flash reader shares rst, so no outstanding read survives.
- Flash reads are never aborted; exactly one fl_rdy is consumed per trigger.
- Conflicting addresses (same idx, different tag) evict each other.

Optional Feature:
- Macro QSPI_FETCH_PREFETCH_EN.
- Defined:
  - After RESP of a miss, if the line for A+4 (wrapping mod 2^AW) is not valid, go to PREF.
  - PREF issues a flash read for A+4 and fills that line. It is not reported to the CPU.
  - A cpu_req arriving during PREF waits until the prefetch fill completes, then is serviced normally (LOOKUP). If it targets A+4 it hits.
  - inv during PREF suppresses valid, same as in FILL.
- Undefined: no PREF state; the flash reader is idle after RESP.

Test Plan:
- Cold miss: after reset, cpu_req with cpu_addr=0x000003 -> fl_addr=0x000000, fl_trigger=1 until fl_rdy with fl_rdata=0xDEADBEEF; cpu_rdy=1 and cpu_rdata=0xDEADBEEF one cycle after fl_rdy; fl_trigger=0 afterwards.
- Hit: repeat cpu_addr=0x000000 -> cpu_rdy=1 one cycle after the request, cpu_rdata=0xDEADBEEF, fl_trigger never asserted.
- Conflict, LINES=16: read 0x000040 (fl_rdata=0x11111111) then 0x000000 -> both miss; 0x000000 refetched from flash; then 0x000040 misses again.
- Invalidate: pulse inv during FILL of 0x000008 (fl_rdata=0xCAFEF00D) -> CPU receives 0xCAFEF00D; next read of 0x000008 triggers the flash again.
- Reset mid-FILL: assert rst while fl_trigger=1 -> next cycle fl_trigger=0, cpu_rdy=0; read of 0x000000 after reset misses.
- With QSPI_FETCH_PREFETCH_EN: miss at 0x000010 with cpu_req held low afterwards -> second flash read with fl_addr=0x000014, and a later read of 0x000014 hits in one cycle; miss at 0xFFFFFC -> prefetch fl_addr=0x000000.
